// File: rtl/uart_loop_engine.sv
// uart_loop_engine: rx word capture, transform, FIFO and paced tx handshake with loop statistics
module uart_loop_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int BUSY_TO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [1:0] mode,
  input  logic [DATA_W-1:0] step,
  input  logic rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic rx_error,
  input  logic tx_ready,
  output logic tx_send,
  output logic [DATA_W-1:0] tx_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic overflow,
  output logic [CNT_W-1:0] loop_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic [DATA_W-1:0] ctr, cap_d, xf, push_d;
  logic rx_q, cap_v, rx_edge, gen, push, pop, push_ok;
  assign rx_edge = rx_valid & ~rx_q;
  assign xf = mode == 2'b01 ? rx_data + step : mode == 2'b10 ? ~rx_data : rx_data;
  assign gen = mode == 2'b11 && enable && state == IDLE && fifo_count == '0 && !cap_v;
  assign pop = state == IDLE && fifo_count != '0 && tx_ready && enable;
  assign push = cap_v | gen;
  assign push_d = cap_v ? cap_d : ctr;
  assign push_ok = push && (fifo_count != FULL || pop);
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= 1'b0;
      cap_v <= 1'b0;
      cap_d <= '0;
      ctr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      err_count <= '0;
      loop_count <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      timer <= '0;
      state <= IDLE;
    end else begin
      rx_q <= rx_valid;
      cap_v <= rx_edge && enable && mode != 2'b11 && !rx_error;
      cap_d <= xf;
      if (rx_edge && enable && rx_error && err_count != '1) err_count <= err_count + CNT_W'(1);
      if (gen) ctr <= ctr + step;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop);
      tx_send <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_send <= 1'b1;
          tx_data <= mem[rd_ptr];
          loop_count <= loop_count + CNT_W'(1);
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!tx_ready) state <= WAIT_DONE;
          else if (timer == TO_LAST) state <= IDLE;
          else timer <= timer + TW'(1);
        WAIT_DONE: if (tx_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_loop_engine.md
Name: uart_loop_engine

Overview:
Parametrised loopback/transform engine placed between a UART receiver's byte interface and a UART transmitter's byte interface, inside the same clock domain as the baud dividers' source clock.
- Captures received words and transforms each one per a runtime mode (pass, add-step, invert, or self-generated counter).
- Buffers results in a FIFO and paces them into the transmitter with a send/ready handshake.
- Provides frame, error and overflow statistics for loop verification.

Parameters:
DATA_W, 8, word width of rx_data/tx_data/step (5..9 legal)
DEPTH, 8, FIFO entries, power of two, >=2
CNT_W, 16, width of loop_count and err_count
BUSY_TO, 64, max cycles to wait for tx_ready to fall after a send pulse

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  1 = engine runs; 0 = no new captures or sends (in-flight send completes)
mode  in  2  00 pass, 01 add step, 10 invert, 11 self counter
step  in  DATA_W  addend for modes 01/11
rx_valid  in  1  receiver word-ready level; new word on each 0->1 edge
rx_data  in  DATA_W  received word, stable while rx_valid high
rx_error  in  1  receiver frame/parity error, sampled with rx_valid edge
tx_ready  in  1  transmitter idle level (1 = idle)
tx_send  out  1  one-cycle send request
tx_data  out  DATA_W  word to transmit, held from tx_send until next send
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: word dropped because FIFO full
loop_count  out  CNT_W  words handed to transmitter, wraps
err_count  out  CNT_W  rx_error events, saturates at all-ones

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, FSM IDLE, internal counter 0, rx_valid edge register 0.
- Capture: on a registered rising edge of rx_valid with enable=1 and mode!=11:
  - If rx_error=1: err_count++ (saturating); the word is discarded.
  - Else: the transformed word is pushed.
    - 00: rx_data
    - 01: rx_data+step mod 2^DATA_W
    - 10: ~rx_data
- Push latency: the word appears in the FIFO the cycle after the edge is detected (2 clk after the rx_valid rise).
- FIFO full on a push: the word is dropped, overflow is set (cleared only by rst), and fifo_count is unchanged.
- Mode 11: rx words are ignored; err_count still counts.
  - When FIFO is empty, FSM is IDLE and enable=1: push the internal counter, then counter += step (wraps).
- Send FSM:
  - IDLE: if FIFO non-empty, tx_ready=1 and enable=1: pop, load tx_data, pulse tx_send for 1 cycle, loop_count++, go to WAIT_BUSY.
  - WAIT_BUSY: on tx_ready=0, go to WAIT_DONE. If BUSY_TO cycles elapse with tx_ready still 1, go to IDLE (lost-send recovery; loop_count not decremented).
  - WAIT_DONE: on tx_ready=1, go to IDLE.
  - Minimum spacing between tx_send pulses is 3 cycles.
- Simultaneous push and pop in the same cycle: both occur and fifo_count is unchanged. This holds when full, because the pop frees the slot first and no overflow occurs.
- A mode change takes effect on the next capture; words already in the FIFO are not retransformed.
- enable=0 mid-send: the FSM finishes WAIT_BUSY/WAIT_DONE, then holds in IDLE.
- rst mid-operation: FIFO contents are lost, tx_send drops immediately, and counters clear.
- FIFO pointers wrap modulo DEPTH; a full FIFO is distinguished from an empty one by fifo_count.

Test Plan:
1. Pass mode, DATA_W=8: rx words 0x41, 0x42 with a tx model (ready falls 2 clk after send, idle 20 clk later) -> tx_data 0x41 then 0x42, loop_count=2, fifo_count returns to 0.
2. Mode 01, step=1: rx 0xFF -> tx_data 0x00 (wrap). Mode 10: rx 0x5A -> tx_data 0xA5.
3. tx_ready held 0, DEPTH=8: 10 rx words -> fifo_count=8, overflow=1. After release, exactly the first 8 words are sent in order.
4. rx_error=1 on 3 of 5 words -> err_count=3, only 2 words transmitted. Force err_count to all-ones then 1 more error -> it stays all-ones.
5. Mode 11, step=3, tx model idle after 10 clk -> tx_data sequence 0x00, 0x03, 0x06, 0x09 with no rx activity. enable=0 -> sends stop after the current one.
6. tx_ready never falls after tx_send -> FSM returns to IDLE after 64 cycles and the next FIFO word is sent. Assert rst mid-WAIT_DONE -> all outputs 0 within the same cycle.
